// File: rtl/lock_pkg.sv
// Shared encodings for the keypad lock supervisor: FSM states, key-decode codes
// and a small elaboration-time helper.
package lock_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ENTRY   = 2'd1,
    OPEN    = 2'd2,
    LOCKOUT = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    K0   = 2'd1,
    K1   = 2'd2,
    BAD  = 2'd3
  } key_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/lock_key_decode.sv
// Per-cycle keypad strobe decode: both keys at once is a digit that can never
// match the code.
module lock_key_decode
  import lock_pkg::*;
(
  input  logic i_in0,
  input  logic i_in1,
  output logic o_vld,
  output logic o_digit,
  output logic o_bad
);

  key_t w_key;

  always_comb begin
    w_key = NONE;
    case ({i_in1, i_in0})
      2'b01:   w_key = K0;
      2'b10:   w_key = K1;
      2'b11:   w_key = BAD;
      default: w_key = NONE;
    endcase
  end

  assign o_vld   = (w_key != NONE);
  assign o_bad   = (w_key == BAD);
  assign o_digit = (w_key == K1);

endmodule

// File: rtl/lock_supervisor.sv
// Supervised keypad lock: programmable code, entry timeout, timed unlock window
// and failed-attempt lockout, all driven from one FSM with a shared timer.
module lock_supervisor
  import lock_pkg::*;
#(
  parameter int              PW_LEN      = 5,
  parameter logic [PW_LEN-1:0] PW_DEFAULT = 5'b11010,
  parameter int              MAX_FAIL    = 3,
  parameter int              OPEN_CYCLES = 8,
  parameter int              LOCK_CYCLES = 16,
  parameter int              TIMEOUT     = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in0,
  input  logic              in1,
  input  logic              cfg_we,
  input  logic [PW_LEN-1:0] cfg_pw,
  output logic              cfg_ack,
  output logic              unlock,
  output logic              alarm,
  output logic [1:0]        state,
  output logic [3:0]        fail_cnt
);

  localparam int TW = $clog2(max3(OPEN_CYCLES, LOCK_CYCLES, TIMEOUT) + 1);
  localparam int IW = $clog2(PW_LEN + 1);

  state_t            r_state;
  logic [PW_LEN-1:0] r_code;
  logic [IW-1:0]     r_idx;
  logic              r_err;
  logic [TW-1:0]     r_timer;
  logic [3:0]        r_fail;
  logic              r_unlock;
  logic              r_alarm;
  logic              r_ack;

  logic          w_vld;
  logic          w_digit;
  logic          w_bad;
  logic [IW-1:0] w_idx_base;
  logic          w_err_base;
  logic          w_code_bit;
  logic          w_err_n;
  logic [IW-1:0] w_idx_n;
  logic          w_done;
  logic [3:0]    w_fail_n;

  lock_key_decode u_dec (
    .i_in0   (in0),
    .i_in1   (in1),
    .o_vld   (w_vld),
    .o_digit (w_digit),
    .o_bad   (w_bad)
  );

  // IDLE starts a fresh attempt, so the first digit sees idx=0 and a clean error flag.
  assign w_idx_base = (r_state == IDLE) ? '0 : r_idx;
  assign w_err_base = (r_state == IDLE) ? 1'b0 : r_err;
  assign w_code_bit = |(r_code & (PW_LEN'(1) << w_idx_base));
  assign w_err_n    = w_err_base | w_bad | (w_digit != w_code_bit);
  assign w_idx_n    = w_idx_base + IW'(1);
  assign w_done     = (w_idx_n == IW'(PW_LEN));
  assign w_fail_n   = r_fail + 4'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_code   <= PW_DEFAULT;
      r_idx    <= '0;
      r_err    <= 1'b0;
      r_timer  <= '0;
      r_fail   <= '0;
      r_unlock <= 1'b0;
      r_alarm  <= 1'b0;
      r_ack    <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      case (r_state)
        IDLE, ENTRY: begin
          if (w_vld) begin
            r_timer <= '0;
            if (w_done) begin
              r_idx <= '0;
              r_err <= 1'b0;
              if (!w_err_n) begin
                r_state  <= OPEN;
                r_unlock <= 1'b1;
                r_fail   <= '0;
              end else if (w_fail_n == 4'(MAX_FAIL)) begin
                r_state <= LOCKOUT;
                r_alarm <= 1'b1;
                r_fail  <= w_fail_n;
              end else begin
                r_state <= IDLE;
                r_fail  <= w_fail_n;
              end
            end else begin
              r_state <= ENTRY;
              r_idx   <= w_idx_n;
              r_err   <= w_err_n;
            end
          end else if (r_state == ENTRY) begin
            // An abandoned attempt is not a failure; fail count is left alone.
            if (r_timer == TW'(TIMEOUT - 1)) begin
              r_state <= IDLE;
              r_idx   <= '0;
              r_err   <= 1'b0;
              r_timer <= '0;
            end else begin
              r_timer <= r_timer + TW'(1);
            end
          end
        end
        OPEN: begin
          if (cfg_we) begin
            r_code <= cfg_pw;
            r_ack  <= 1'b1;
          end
          if (r_timer == TW'(OPEN_CYCLES - 1)) begin
            r_state  <= IDLE;
            r_unlock <= 1'b0;
            r_timer  <= '0;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        LOCKOUT: begin
          if (r_timer == TW'(LOCK_CYCLES - 1)) begin
            r_state <= IDLE;
            r_alarm <= 1'b0;
            r_fail  <= '0;
            r_timer <= '0;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign state    = r_state;
  assign unlock   = r_unlock;
  assign alarm    = r_alarm;
  assign cfg_ack  = r_ack;
  assign fail_cnt = r_fail;

endmodule

// File: tb/tb_lock_supervisor.sv
// Scoreboard bench for lock_supervisor: a queue-based attempt model predicts the
// outputs of every cycle; a negedge monitor pops and compares.
module tb_lock_supervisor;

  localparam int          PW_LEN      = 5;
  localparam logic [4:0]  PW_DEFAULT  = 5'b11010;
  localparam int          MAX_FAIL    = 3;
  localparam int          OPEN_CYCLES = 8;
  localparam int          LOCK_CYCLES = 16;
  localparam int          TIMEOUT     = 12;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       in0 = 1'b0;
  logic       in1 = 1'b0;
  logic       cfg_we = 1'b0;
  logic [4:0] cfg_pw = '0;
  logic       cfg_ack;
  logic       unlock;
  logic       alarm;
  logic [1:0] state;
  logic [3:0] fail_cnt;

  lock_supervisor dut (
    .clk      (clk),
    .reset    (reset),
    .in0      (in0),
    .in1      (in1),
    .cfg_we   (cfg_we),
    .cfg_pw   (cfg_pw),
    .cfg_ack  (cfg_ack),
    .unlock   (unlock),
    .alarm    (alarm),
    .state    (state),
    .fail_cnt (fail_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] st;
    logic       ul;
    logic       al;
    logic       ack;
    logic [3:0] fc;
  } obs_t;

  obs_t exp_q[$];
  int   ph_q[$];
  int   total = 0;
  int   bad = 0;
  int   ncyc = 0;

  // Model: mode 0..3 = idle/entry/open/lockout; digits collected so far.
  int         m_mode = 0;
  int         m_digits[$];
  int         m_idle = 0;
  int         m_left = 0;
  int         m_fail = 0;
  logic [4:0] m_code = PW_DEFAULT;
  bit         m_ack = 0;

  function automatic void model_step(bit r, int d, bit w, logic [4:0] p);
    bit ok;
    m_ack = 0;
    if (r) begin
      m_mode = 0; m_digits.delete(); m_idle = 0; m_left = 0;
      m_fail = 0; m_code = PW_DEFAULT;
      return;
    end
    case (m_mode)
      0, 1: begin
        if (d >= 0) begin
          m_digits.push_back(d);
          m_idle = 0;
          if (m_digits.size() == PW_LEN) begin
            ok = 1;
            foreach (m_digits[i]) if (m_digits[i] != int'(m_code[i])) ok = 0;
            m_digits.delete();
            if (ok) begin
              m_mode = 2; m_left = OPEN_CYCLES; m_fail = 0;
            end else begin
              m_fail++;
              if (m_fail == MAX_FAIL) begin m_mode = 3; m_left = LOCK_CYCLES; end
              else m_mode = 0;
            end
          end else m_mode = 1;
        end else if (m_mode == 1) begin
          m_idle++;
          if (m_idle == TIMEOUT) begin m_mode = 0; m_digits.delete(); m_idle = 0; end
        end
      end
      2: begin
        if (w) begin m_code = p; m_ack = 1; end
        m_left--;
        if (m_left == 0) m_mode = 0;
      end
      default: begin
        m_left--;
        if (m_left == 0) begin m_mode = 0; m_fail = 0; end
      end
    endcase
  endfunction

  // d: -1 none, 0/1 digit, 2 both keys
  task automatic cyc(input bit r, input int d, input bit w, input logic [4:0] p, input int ph);
    obs_t e;
    reset = r; in0 = (d == 0 || d == 2); in1 = (d == 1 || d == 2);
    cfg_we = w; cfg_pw = p;
    @(posedge clk);
    model_step(r, d, w, p);
    e.st = 2'(m_mode); e.ul = (m_mode == 2); e.al = (m_mode == 3);
    e.ack = m_ack; e.fc = 4'(m_fail);
    exp_q.push_back(e);
    ph_q.push_back(ph);
    #1;
  endtask

  task automatic idle(input int n, input int ph);
    for (int i = 0; i < n; i++) cyc(0, -1, 0, 5'd0, ph);
  endtask

  task automatic enter(input logic [4:0] c, input int ph);
    for (int i = 0; i < PW_LEN; i++) cyc(0, int'(c[i]), 0, 5'd0, ph);
  endtask

  always @(negedge clk) begin
    obs_t e;
    int ph;
    ncyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      ph = ph_q.pop_front();
      total++;
      if ({state, unlock, alarm, cfg_ack, fail_cnt} !== e) begin
        bad++;
        $display("FAIL outputs phase=%0d cyc=%0d got st=%0d ul=%0b al=%0b ack=%0b fc=%0d exp st=%0d ul=%0b al=%0b ack=%0b fc=%0d",
                 ph, ncyc, state, unlock, alarm, cfg_ack, fail_cnt, e.st, e.ul, e.al, e.ack, e.fc);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int d, r, nxt;
    // 1: reset and default code
    cyc(1, -1, 0, 5'd0, 1); cyc(1, -1, 0, 5'd0, 1);
    enter(PW_DEFAULT, 1); idle(10, 1);
    // 2: three wrong attempts -> lockout, keys pressed during lockout
    for (int k = 0; k < 3; k++) begin enter(5'b11110, 2); idle(2, 2); end
    for (int i = 0; i < 16; i++) cyc(0, $urandom_range(0, 2), 1, 5'b10101, 2);
    idle(4, 2);
    // 3: timeout then a good code
    cyc(0, 0, 0, 5'd0, 3); cyc(0, 1, 0, 5'd0, 3); idle(12, 3);
    enter(PW_DEFAULT, 3);
    // 4: reprogram while open, ignored write in idle, old code fails, new passes
    cyc(0, 1, 1, 5'b00111, 4); idle(9, 4);
    cyc(0, -1, 1, 5'b01010, 4); idle(2, 4);
    enter(PW_DEFAULT, 4); idle(1, 4);
    enter(5'b00111, 4); idle(9, 4);
    // 5: both keys as digit 2 of an otherwise correct code
    cyc(0, 1, 0, 5'd0, 5); cyc(0, 2, 0, 5'd0, 5);
    cyc(0, 1, 0, 5'd0, 5); cyc(0, 0, 0, 5'd0, 5); cyc(0, 0, 0, 5'd0, 5);
    idle(2, 5);
    // 6: reset mid-entry and mid-open
    cyc(0, 1, 0, 5'd0, 6); cyc(0, 1, 0, 5'd0, 6); cyc(1, 1, 0, 5'd0, 6);
    enter(PW_DEFAULT, 6); idle(3, 6); cyc(1, -1, 0, 5'd0, 6); idle(2, 6);
    enter(PW_DEFAULT, 6); idle(9, 6);
    // 7: randomized traffic, biased toward the correct next digit
    for (int n = 0; n < 1500; n++) begin
      r = $urandom_range(0, 199);
      if (r < 3) begin idle(13, 7); continue; end
      nxt = (m_mode <= 1 && m_digits.size() < PW_LEN) ? int'(m_code[m_digits.size()]) : 0;
      case ($urandom_range(0, 5))
        0, 1:    d = -1;
        2, 3:    d = nxt;
        4:       d = $urandom_range(0, 1);
        default: d = ($urandom_range(0, 3) == 0) ? 2 : nxt;
      endcase
      cyc(r == 3, d, $urandom_range(0, 7) == 0, 5'($urandom_range(0, 31)), 7);
    end
    idle(2, 8);
    @(negedge clk); @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d exp=0 pending expectations", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
